// File: rtl/d_mem_lsu_pkg.sv
// Shared definitions for the d_mem load/store unit: funct3 codes, FSM states, lane-mask helper.
// Latency: none (declarations only).
// Backpressure: not applicable.
package d_mem_lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef logic [1:0] lsu_state_t;
   localparam lsu_state_t IDLE = 2'd0;
   localparam lsu_state_t ACC0 = 2'd1;
   localparam lsu_state_t ACC1 = 2'd2;
   localparam lsu_state_t RESP = 2'd3;

   // Byte-lane mask across two adjacent words: (2^size - 1) shifted by the byte offset.
   function automatic logic [7:0] size_mask(input logic [1:0] sz, input logic [1:0] off);
      logic [7:0] m;
      case (sz)
         2'b00:   m = 8'h01;
         2'b01:   m = 8'h03;
         default: m = 8'h0F;
      endcase
      return m << off;
   endfunction

endpackage

// File: rtl/d_mem_lsu_align.sv
// Request decode, store lane shifting and load extraction/extension for the LSU.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module lsu_align
   import d_mem_lsu_pkg::*;
#(
   parameter int MEM_SIZE_WORDS   = 256,
   parameter int ALLOW_MISALIGNED = 1
) (
   input  logic        we,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [63:0] rd64,
   output logic [7:0]  mask8,
   output logic        split,
   output logic [31:0] w0,
   output logic [31:0] w1,
   output logic        legal,
   output logic [63:0] wr64,
   output logic [31:0] ld_data
);

   logic [1:0]  off;
   logic        f3_ok;
   logic [63:0] ld_sh;
   logic [31:0] ld_raw;

   // Decode size/offset, check legality, shift store data up and load data down.
   always_comb begin
      off    = addr[1:0];
      mask8  = size_mask(funct3[1:0], off);
      split  = |mask8[7:4];
      w0     = {2'b00, addr[31:2]};
      w1     = w0 + 32'd1;
      if (we)
         f3_ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
      else
         f3_ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                 (funct3 == F3_BU) || (funct3 == F3_HU);
      legal  = f3_ok &&
               (w0 < 32'(MEM_SIZE_WORDS)) &&
               !(split && (w1 >= 32'(MEM_SIZE_WORDS))) &&
               ((ALLOW_MISALIGNED != 0) || (off == 2'b00));
      wr64   = {32'h0, wdata} << {off, 3'b000};
      ld_sh  = rd64 >> {off, 3'b000};
      ld_raw = ld_sh[31:0];
      case (funct3)
         F3_B:    ld_data = {{24{ld_raw[7]}}, ld_raw[7:0]};
         F3_H:    ld_data = {{16{ld_raw[15]}}, ld_raw[15:0]};
         F3_BU:   ld_data = {24'h0, ld_raw[7:0]};
         F3_HU:   ld_data = {16'h0, ld_raw[15:0]};
         default: ld_data = ld_raw;
      endcase
   end

endmodule

// File: rtl/d_mem_lsu.sv
// Load/store initiator for d_mem: aligns stores, extends loads, splits word-crossing accesses.
// Latency: response 2 cycles after accept (3 if split, 1 on error).
// Backpressure: req_ready low while busy; response is a one-cycle pulse with no stall.
module d_mem_lsu
   import d_mem_lsu_pkg::*;
#(
   parameter int MEM_SIZE_WORDS   = 256,
   parameter int ALLOW_MISALIGNED = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] mem_addr,
   output logic        mem_wr_en,
   output logic [31:0] mem_wr_data,
   output logic [3:0]  mem_byte_en,
   input  logic [31:0] mem_rd_data
);

   lsu_state_t  state;
   logic        q_we;
   logic [2:0]  q_funct3;
   logic [31:0] q_addr;
   logic [31:0] q_wdata;
   logic [31:0] rd_buf;

   logic        a_we;
   logic [2:0]  a_funct3;
   logic [31:0] a_addr;
   logic [31:0] a_wdata;
   logic [63:0] rd64;
   logic [7:0]  mask8;
   logic        split;
   logic [31:0] w0;
   logic [31:0] w1;
   logic        legal;
   logic [63:0] wr64;
   logic [31:0] ld_data;

   // Decode the live request while idle, the latched one otherwise; the second word joins the buffer in ACC1.
   always_comb begin
      a_we     = (state == IDLE) ? req_we     : q_we;
      a_funct3 = (state == IDLE) ? req_funct3 : q_funct3;
      a_addr   = (state == IDLE) ? req_addr   : q_addr;
      a_wdata  = (state == IDLE) ? req_wdata  : q_wdata;
      rd64     = (state == ACC1) ? {mem_rd_data, rd_buf} : {32'h0, mem_rd_data};
   end

   lsu_align #(
      .MEM_SIZE_WORDS  (MEM_SIZE_WORDS),
      .ALLOW_MISALIGNED(ALLOW_MISALIGNED)
   ) u_align (
      .we     (a_we),
      .funct3 (a_funct3),
      .addr   (a_addr),
      .wdata  (a_wdata),
      .rd64   (rd64),
      .mask8  (mask8),
      .split  (split),
      .w0     (w0),
      .w1     (w1),
      .legal  (legal),
      .wr64   (wr64),
      .ld_data(ld_data)
   );

   // FSM with registered memory-port and response outputs; memory strobes default low every cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         req_ready   <= 1'b1;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= 32'h0;
         rsp_err     <= 1'b0;
         mem_addr    <= 32'h0;
         mem_wr_en   <= 1'b0;
         mem_wr_data <= 32'h0;
         mem_byte_en <= 4'h0;
         q_we        <= 1'b0;
         q_funct3    <= 3'h0;
         q_addr      <= 32'h0;
         q_wdata     <= 32'h0;
         rd_buf      <= 32'h0;
      end else begin
         rsp_valid   <= 1'b0;
         mem_wr_en   <= 1'b0;
         mem_byte_en <= 4'h0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  q_we      <= req_we;
                  q_funct3  <= req_funct3;
                  q_addr    <= req_addr;
                  q_wdata   <= req_wdata;
                  req_ready <= 1'b0;
                  if (legal) begin
                     state       <= ACC0;
                     mem_addr    <= w0;
                     mem_byte_en <= mask8[3:0];
                     mem_wr_en   <= req_we;
                     mem_wr_data <= wr64[31:0];
                  end else begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_rdata <= 32'h0;
                  end
               end
            end
            ACC0: begin
               rd_buf <= mem_rd_data;
               if (split) begin
                  state       <= ACC1;
                  mem_addr    <= w1;
                  mem_byte_en <= mask8[7:4];
                  mem_wr_en   <= q_we;
                  mem_wr_data <= wr64[63:32];
               end else begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  rsp_rdata <= q_we ? 32'h0 : ld_data;
               end
            end
            ACC1: begin
               state     <= RESP;
               rsp_valid <= 1'b1;
               rsp_err   <= 1'b0;
               rsp_rdata <= q_we ? 32'h0 : ld_data;
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_d_mem_lsu.sv
// Self-checking bench for d_mem_lsu with an attached word-array memory model.
// Latency: responses are matched against a scoreboard that records expected cycle counts.
// Backpressure: one request in flight; the driver waits for req_ready.
module tb_d_mem_lsu;
   import d_mem_lsu_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, mem_clr;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic [31:0] mem_addr, mem_wr_data, mem_rd_data;
   logic        mem_wr_en;
   logic [3:0]  mem_byte_en;

   logic        na_req_valid, na_req_ready, na_rsp_valid, na_rsp_err, na_wr_en;
   logic [31:0] na_rsp_rdata, na_addr, na_wr_data, na_rd_data;
   logic [3:0]  na_byte_en;

   d_mem_lsu #(.MEM_SIZE_WORDS(256), .ALLOW_MISALIGNED(1)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
      .mem_byte_en(mem_byte_en), .mem_rd_data(mem_rd_data));

   d_mem_lsu #(.MEM_SIZE_WORDS(256), .ALLOW_MISALIGNED(0)) dut_na (
      .clk(clk), .rst(rst), .req_valid(na_req_valid), .req_ready(na_req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(na_rsp_valid), .rsp_rdata(na_rsp_rdata), .rsp_err(na_rsp_err),
      .mem_addr(na_addr), .mem_wr_en(na_wr_en), .mem_wr_data(na_wr_data),
      .mem_byte_en(na_byte_en), .mem_rd_data(na_rd_data));

   // Memory model: byte-lane writes at the clock edge, combinational lane-masked reads.
   logic [31:0] mem_arr [0:255];
   int          wr_cnt;
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 256; i++) mem_arr[i] <= 32'h0;
         wr_cnt <= 0;
      end else if (mem_wr_en) begin
         wr_cnt <= wr_cnt + 1;
         if (mem_addr < 32'd256)
            for (int b = 0; b < 4; b++)
               if (mem_byte_en[b]) mem_arr[mem_addr[7:0]][8*b +: 8] <= mem_wr_data[8*b +: 8];
      end
   end

   always_comb begin
      mem_rd_data = 32'h0;
      if (mem_addr < 32'd256)
         for (int b = 0; b < 4; b++)
            if (mem_byte_en[b]) mem_rd_data[8*b +: 8] = mem_arr[mem_addr[7:0]][8*b +: 8];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          acc;
      int          lat;
   } exp_t;
   exp_t sb[$];

   // Response monitor: every pulse must match the oldest expectation, including its latency.
   always @(negedge clk) begin
      if (rsp_valid) begin
         if (sb.size() == 0) begin
            chk("rsp_unexpected", {31'h0, rsp_valid}, 32'h0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
            chk("rsp_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
         end
      end
   end

   // Present one request; returns 1ns into the cycle after the accepting edge.
   task automatic start(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] er, input logic ee, input int el);
      int n;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      sb.push_back('{er, ee, cyc, el});
   endtask

   task automatic finish_req(input string tag);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_done"}, 32'(sb.size()), 32'h0);
      sb.delete();
   endtask

   // Request to the ALLOW_MISALIGNED=0 instance that must be rejected in the next cycle.
   task automatic na_reject(input logic [2:0] f3, input logic [31:0] a, input string tag);
      @(negedge clk);
      req_we = 1'b0; req_funct3 = f3; req_addr = a; na_req_valid = 1'b1;
      @(posedge clk);
      #1;
      na_req_valid = 1'b0;
      chk({tag, "_vld"}, {31'h0, na_rsp_valid}, 32'h1);
      chk({tag, "_err"}, {31'h0, na_rsp_err}, 32'h1);
      chk({tag, "_be"}, {28'h0, na_byte_en}, 32'h0);
      @(posedge clk);
      #1;
      chk({tag, "_be2"}, {28'h0, na_byte_en}, 32'h0);
   endtask

   initial begin
      int w;
      rst = 1'b1; mem_clr = 1'b1; req_valid = 1'b0; na_req_valid = 1'b0;
      req_we = 1'b0; req_funct3 = 3'h0; req_addr = 32'h0; req_wdata = 32'h0; na_rd_data = 32'h0;
      repeat (3) @(posedge clk);
      #1 mem_clr = 1'b0;
      @(negedge clk);
      chk("rst_ready", {31'h0, req_ready}, 32'h1);
      chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      chk("rst_rdata", rsp_rdata, 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_be", {28'h0, mem_byte_en}, 32'h0);
      chk("rst_wr_en", {31'h0, mem_wr_en}, 32'h0);
      rst = 1'b0;

      start(1'b1, F3_W, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2);
      chk("sw_addr", mem_addr, 32'h4);
      chk("sw_be", {28'h0, mem_byte_en}, 32'hF);
      chk("sw_wr_en", {31'h0, mem_wr_en}, 32'h1);
      chk("sw_wdata", mem_wr_data, 32'hDEADBEEF);
      chk("busy_ready", {31'h0, req_ready}, 32'h0);
      finish_req("sw");
      chk("mem_word4", mem_arr[4], 32'hDEADBEEF);

      start(1'b0, F3_W,  32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2); finish_req("lw");
      start(1'b0, F3_B,  32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, 2); finish_req("lb");
      start(1'b0, F3_BU, 32'h13, 32'h0, 32'h000000DE, 1'b0, 2); finish_req("lbu");
      start(1'b0, F3_H,  32'h12, 32'h0, 32'hFFFFDEAD, 1'b0, 2); finish_req("lh");
      start(1'b0, F3_HU, 32'h10, 32'h0, 32'h0000BEEF, 1'b0, 2); finish_req("lhu");

      start(1'b1, F3_W, 32'h14, 32'h00000077, 32'h0, 1'b0, 2); finish_req("sw5");
      start(1'b0, F3_W, 32'h11, 32'h0, 32'h77DEADBE, 1'b0, 3);
      chk("split0_addr", mem_addr, 32'h4);
      chk("split0_be", {28'h0, mem_byte_en}, 32'hE);
      chk("split0_wr_en", {31'h0, mem_wr_en}, 32'h0);
      @(posedge clk);
      #1;
      chk("split1_addr", mem_addr, 32'h5);
      chk("split1_be", {28'h0, mem_byte_en}, 32'h1);
      finish_req("split_lw");

      start(1'b1, F3_H, 32'h12, 32'h00001234, 32'h0, 1'b0, 2);
      chk("sh_be", {28'h0, mem_byte_en}, 32'hC);
      chk("sh_wdata", mem_wr_data, 32'h12340000);
      finish_req("sh");
      start(1'b0, F3_W, 32'h10, 32'h0, 32'h1234BEEF, 1'b0, 2); finish_req("lw_after_sh");

      w = wr_cnt;
      start(1'b0, F3_W, 32'h400, 32'h0, 32'h0, 1'b1, 1);
      chk("ill_lw_be", {28'h0, mem_byte_en}, 32'h0);
      finish_req("ill_lw");
      start(1'b1, F3_H, 32'h3FF, 32'h0000FFFF, 32'h0, 1'b1, 1); finish_req("ill_sh");
      start(1'b1, F3_BU, 32'h10, 32'h000000FF, 32'h0, 1'b1, 1); finish_req("ill_sb");
      chk("ill_no_write", 32'(wr_cnt - w), 32'h0);
      chk("ill_word4", mem_arr[4], 32'h1234BEEF);
      chk("ill_word255", mem_arr[255], 32'h0);

      na_reject(F3_W, 32'h11, "na_split");
      na_reject(F3_H, 32'h12, "na_misal");

      start(1'b1, F3_W, 32'h11, 32'hAABBCCDD, 32'h0, 1'b0, 3);
      sb.delete();
      chk("rst_mid_be", {28'h0, mem_byte_en}, 32'hE);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_mid_ready", {31'h0, req_ready}, 32'h1);
      chk("rst_mid_be_off", {28'h0, mem_byte_en}, 32'h0);
      chk("rst_mid_word4", mem_arr[4], 32'hBBCCDDEF);
      chk("rst_mid_word5", mem_arr[5], 32'h00000077);
      repeat (4) @(negedge clk);
      start(1'b0, F3_W, 32'h10, 32'h0, 32'hBBCCDDEF, 1'b0, 2); finish_req("lw_post_rst");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
